adc_scan_sequencer: RTL and testbench
=====================================

# adc_scan_sequencer

Parametrised multi-channel conversion sequencer that sits between the system configuration/start interface and the SAR conversion core. On a start request it walks every enabled analog channel in ascending order, drives the input mux, waits a settling time, and issues 2^osr back-to-back core conversions per channel. It accumulates each channel's samples into an averaged or summed result tagged with the channel number, and supports single-scan, continuous-scan, abort and core-timeout recovery.

## Interface
Parameters:
- RAW_W, 12, width of one core conversion result
- OUT_W, 16, width of result_out; must be ≥ RAW_W+OSR_MAX_LOG2
- NCH, 4, number of analog channels (≥2); CH_W = $clog2(NCH)
- OSR_MAX_LOG2, 4, largest oversampling exponent; OSR_W = $clog2(OSR_MAX_LOG2+1)
- SETTLE_CYC, 8, settle cycles after a mux change (≥1)
- TIMEOUT_CYC, 64, max cycles from core_start_out to core_done_in

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_conversion_in  in  1  scan request, sampled in IDLE only
- continuous_in  in  1  restart a new scan when the current one ends
- abort_in  in  1  terminate activity, return to IDLE
- ch_mask_in  in  NCH  channel enable, bit i = channel i
- osr_log2_in  in  OSR_W  samples per channel = 2^osr_log2_in
- avg_en_in  in  1  1: result = sum>>osr; 0: raw sum
- core_start_out  out  1  one-cycle conversion request to SAR core
- core_done_in  in  1  one-cycle core completion strobe
- core_result_in  in  RAW_W  valid when core_done_in=1
- mux_sel_out  out  CH_W  analog channel select
- result_out  out  OUT_W  channel result, zero-extended
- result_ch_out  out  CH_W  channel of result_out
- result_valid_out  out  1  one-cycle result strobe
- scan_done_out  out  1  one-cycle end-of-scan strobe
- busy_out  out  1  high in any state except IDLE
- timeout_out  out  1  sticky core-timeout flag

## Operation
- States: IDLE, SETTLE, CONV, EMIT.
- IDLE: start_conversion_in=1 with ch_mask_in≠0 → latch ch_mask, osr (clamped to OSR_MAX_LOG2), avg_en; clear timeout_out; mux_sel_out ← lowest enabled channel; → SETTLE. Start with mask=0 is ignored. Start while busy is ignored.
- SETTLE: counts SETTLE_CYC cycles, then core_start_out pulses, counters clear → CONV.
- CONV: accumulator (RAW_W+OSR_MAX_LOG2 bits, cleared on channel entry) adds core_result_in on each core_done_in; sample counter increments. If count < 2^osr, core_start_out pulses the cycle after core_done_in (no re-settle). On the 2^osr-th done → EMIT. core_done_in outside CONV is ignored.
- Timeout: cycle counter restarts at each core_start_out; reaching TIMEOUT_CYC without done → timeout_out=1, channel abandoned (no result_valid_out), proceed as after EMIT.
- EMIT: result_out = avg_en ? acc>>osr : acc, zero-extended; result_ch_out = mux_sel_out; result_valid_out=1 for one cycle. Then the next higher enabled channel → SETTLE; if none, scan_done_out=1 in the same cycle, and continuous_in=1 → re-latch config and restart from the lowest enabled channel (mask=0 at that point → IDLE); otherwise → IDLE.
- abort_in (any state) → IDLE next cycle; no result_valid_out or scan_done_out; accumulators cleared; timeout_out retained. Abort beats start and done in the same cycle.
- Config inputs are ignored mid-scan; only latched at scan start/restart.

## Timing
- Reset: all outputs 0, mux_sel_out=0, state IDLE, accumulators 0.
- Start sampled at edge N → busy_out and new mux_sel_out at N+1; first core_start_out at N+1+SETTLE_CYC.
- core_done_in at edge M (not last sample) → core_start_out at M+1.
- Last core_done_in at edge M → result_valid_out at M+1; next channel's mux_sel_out at M+2.
- Timeout: core_start_out at T, no done → timeout_out at T+TIMEOUT_CYC; next channel mux change at T+TIMEOUT_CYC+1.
- scan_done_out coincides with the final channel's result_valid_out (or the timeout-skip cycle); busy_out drops the cycle after unless continuous.
- done and timeout on the same cycle: done wins.

## Test plan
- Mask=4'b0101, osr=0, avg=1, core returns 12'h123 / 12'h456 → two results (ch0=16'h0123, ch2=16'h0456), scan_done with ch2 result, 2 core_start pulses, mux 0→2.
- Mask=4'b0010, osr=2, avg=1, results 100,101,102,103 → result 101 (406>>2); avg=0 → 406; core_start spacing 1 cycle after each done.
- osr_log2_in=7 with OSR_MAX_LOG2=4 → 16 conversions; all 12'hFFF → avg 16'h0FFF, sum 16'hFFF0.
- Core never responds on ch1, mask=4'b0011 → ch0 result, timeout_out=1 at start+64, no ch1 result, scan_done, busy drops.
- continuous_in=1, mask changed mid-scan from 4'b0001 to 4'b1000 → current scan finishes on ch0, next scan uses ch3; abort mid-CONV → IDLE next cycle, no strobes.
- Start with mask=0 → no activity; rst asserted mid-CONV → all outputs 0 next cycle.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: walks enabled ADC channels in ascending order, oversamples each via the SAR core, emits per-channel results
// Ports: start_conversion_in/continuous_in/abort_in/ch_mask_in/osr_log2_in/avg_en_in configure and control scans;
// core_start_out/core_done_in/core_result_in handshake with the SAR core; mux_sel_out drives the analog mux;
// result_out/result_ch_out/result_valid_out carry results; scan_done_out, busy_out, timeout_out report status.
module adc_scan_sequencer #(
  parameter int RAW_W = 12,
  parameter int OUT_W = 16,
  parameter int NCH = 4,
  parameter int OSR_MAX_LOG2 = 4,
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT_CYC = 64,
  localparam int CH_W = $clog2(NCH),
  localparam int OSR_W = $clog2(OSR_MAX_LOG2 + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_conversion_in,
  input  logic             continuous_in,
  input  logic             abort_in,
  input  logic [NCH-1:0]   ch_mask_in,
  input  logic [OSR_W-1:0] osr_log2_in,
  input  logic             avg_en_in,
  output logic             core_start_out,
  input  logic             core_done_in,
  input  logic [RAW_W-1:0] core_result_in,
  output logic [CH_W-1:0]  mux_sel_out,
  output logic [OUT_W-1:0] result_out,
  output logic [CH_W-1:0]  result_ch_out,
  output logic             result_valid_out,
  output logic             scan_done_out,
  output logic             busy_out,
  output logic             timeout_out
);
  localparam int ACC_W = RAW_W + OSR_MAX_LOG2;
  localparam int ST_W = $clog2(SETTLE_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, CONV = 2'd2, EMIT = 2'd3;
  logic [1:0] state_q, state_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [OSR_W-1:0] osr_q, osr_d, osr_in;
  logic avg_q, avg_d, skip_q, skip_d, start_q, start_d, tmo_flag_q, tmo_flag_d;
  logic [CH_W-1:0] mux_q, mux_d, first_ch, nxt_ch;
  logic [ST_W-1:0] settle_q, settle_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic [OSR_MAX_LOG2-1:0] smp_q, smp_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic has_next, launch;
  assign osr_in = osr_log2_in > OSR_W'(OSR_MAX_LOG2) ? OSR_W'(OSR_MAX_LOG2) : osr_log2_in;
  // descending scans so the last hit is the lowest qualifying channel
  always_comb begin
    first_ch = '0;
    nxt_ch = '0;
    has_next = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask_in[i]) first_ch = CH_W'(i);
      if (mask_q[i] && CH_W'(i) > mux_q) begin
        has_next = 1'b1;
        nxt_ch = CH_W'(i);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    osr_d = osr_q;
    avg_d = avg_q;
    skip_d = skip_q;
    tmo_flag_d = tmo_flag_q;
    mux_d = mux_q;
    settle_d = settle_q;
    tmo_d = tmo_q;
    smp_d = smp_q;
    acc_d = acc_q;
    start_d = 1'b0;
    launch = 1'b0;
    case (state_q)
      IDLE: launch = start_conversion_in && |ch_mask_in;
      SETTLE:
        if (settle_q == ST_W'(SETTLE_CYC - 1)) begin
          state_d = CONV;
          start_d = 1'b1;
          tmo_d = '0;
          // remaining-samples counter: 2^osr - 1 more dones after the first
          smp_d = OSR_MAX_LOG2'((32'd1 << osr_q) - 32'd1);
        end else settle_d = settle_q + 1'b1;
      CONV:
        if (core_done_in) begin
          acc_d = acc_q + ACC_W'(core_result_in);
          if (smp_q == '0) begin
            state_d = EMIT;
            skip_d = 1'b0;
          end else begin
            smp_d = smp_q - 1'b1;
            start_d = 1'b1;
            tmo_d = '0;
          end
        end else if (tmo_q == TO_W'(TIMEOUT_CYC - 1)) begin
          // abandoned channel still passes through EMIT so scan sequencing is shared
          state_d = EMIT;
          skip_d = 1'b1;
          tmo_flag_d = 1'b1;
        end else tmo_d = tmo_q + 1'b1;
      default:
        if (has_next) begin
          state_d = SETTLE;
          mux_d = nxt_ch;
          settle_d = '0;
          acc_d = '0;
        end else if (continuous_in && |ch_mask_in) launch = 1'b1;
        else state_d = IDLE;
    endcase
    if (launch) begin
      state_d = SETTLE;
      mask_d = ch_mask_in;
      osr_d = osr_in;
      avg_d = avg_en_in;
      mux_d = first_ch;
      settle_d = '0;
      acc_d = '0;
    end
    if (launch && state_q == IDLE) tmo_flag_d = 1'b0;
    if (abort_in) begin
      state_d = IDLE;
      acc_d = '0;
      start_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q <= '0;
      osr_q <= '0;
      avg_q <= 1'b0;
      skip_q <= 1'b0;
      tmo_flag_q <= 1'b0;
      mux_q <= '0;
      settle_q <= '0;
      tmo_q <= '0;
      smp_q <= '0;
      acc_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      osr_q <= osr_d;
      avg_q <= avg_d;
      skip_q <= skip_d;
      tmo_flag_q <= tmo_flag_d;
      mux_q <= mux_d;
      settle_q <= settle_d;
      tmo_q <= tmo_d;
      smp_q <= smp_d;
      acc_q <= acc_d;
      start_q <= start_d;
    end
  end
  assign result_valid_out = state_q == EMIT && !skip_q;
  assign scan_done_out = state_q == EMIT && !has_next;
  assign result_out = result_valid_out ? OUT_W'(avg_q ? acc_q >> osr_q : acc_q) : '0;
  assign result_ch_out = result_valid_out ? mux_q : '0;
  assign busy_out = state_q != IDLE;
  assign core_start_out = start_q;
  assign mux_sel_out = mux_q;
  assign timeout_out = tmo_flag_q;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: scoreboard bench with a SAR core model for adc_scan_sequencer
module tb_adc_scan_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic start_conversion_in = 1'b0, continuous_in = 1'b0, abort_in = 1'b0, avg_en_in = 1'b0;
  logic [3:0] ch_mask_in = '0;
  logic [2:0] osr_log2_in = '0;
  logic core_done_in = 1'b0;
  logic [11:0] core_result_in = '0;
  logic core_start_out, result_valid_out, scan_done_out, busy_out, timeout_out;
  logic [1:0] mux_sel_out, result_ch_out;
  logic [15:0] result_out;
  int checks = 0, errors = 0;
  int exp_ch[$], exp_val[$];
  logic [11:0] core_vals[$];
  int lat_cnt = -1, mute_ch = -1, start_cnt = 0, done_cnt = 0, follow_cnt = 0;
  int cyc = 0, t_start = 0, tmo_gap = -1, done_ch = -1;
  logic tmo_prev = 1'b0;

  always #5 clk = ~clk;

  adc_scan_sequencer dut (
    .clk(clk), .rst(rst), .start_conversion_in(start_conversion_in), .continuous_in(continuous_in),
    .abort_in(abort_in), .ch_mask_in(ch_mask_in), .osr_log2_in(osr_log2_in), .avg_en_in(avg_en_in),
    .core_start_out(core_start_out), .core_done_in(core_done_in), .core_result_in(core_result_in),
    .mux_sel_out(mux_sel_out), .result_out(result_out), .result_ch_out(result_ch_out),
    .result_valid_out(result_valid_out), .scan_done_out(scan_done_out), .busy_out(busy_out),
    .timeout_out(timeout_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor + core model; core answers 2 cycles after a request unless the channel is muted
  always @(negedge clk) begin
    cyc++;
    if (core_start_out) begin
      start_cnt++;
      t_start = cyc;
      if (core_done_in) follow_cnt++;
    end
    if (timeout_out && !tmo_prev) tmo_gap = cyc - t_start;
    tmo_prev = timeout_out;
    if (scan_done_out) begin
      done_cnt++;
      done_ch = result_valid_out ? int'(result_ch_out) : -2;
    end
    if (result_valid_out) begin
      if (exp_ch.size() == 0) check("result_expected", exp_ch.size(), 1);
      else begin
        check("result_ch", result_ch_out, exp_ch.pop_front());
        check("result_val", result_out, exp_val.pop_front());
      end
    end
    core_done_in = 1'b0;
    if (lat_cnt == 0) begin
      core_done_in = 1'b1;
      core_result_in = core_vals.size() > 0 ? core_vals.pop_front() : 12'h0;
    end
    if (lat_cnt >= 0) lat_cnt--;
    if (core_start_out && int'(mux_sel_out) != mute_ch) lat_cnt = 1;
    if (rst) lat_cnt = -1;
  end

  task automatic start_scan(input logic [3:0] m, input logic [2:0] o, input logic a, input logic c);
    ch_mask_in = m;
    osr_log2_in = o;
    avg_en_in = a;
    continuous_in = c;
    start_conversion_in = 1'b1;
    @(negedge clk);
    start_conversion_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    do begin @(negedge clk); k++; end while (busy_out && k < budget);
    check(tag, busy_out, 0);
    @(negedge clk);
  endtask

  task automatic wait_core_start(input string tag);
    int k = 0;
    while (!core_start_out && k < 100) begin @(negedge clk); k++; end
    check(tag, core_start_out, 1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0, s0, f0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_out, 0);
    check("rst_mux", mux_sel_out, 0);
    check("rst_core_start", core_start_out, 0);
    check("rst_valid", result_valid_out, 0);
    check("rst_result", result_out, 0);
    check("rst_scan_done", scan_done_out, 0);
    check("rst_timeout", timeout_out, 0);
    rst = 1'b0;
    @(negedge clk);
    // two channels, single sample each
    core_vals = '{12'h123, 12'h456};
    exp_ch = '{0, 2};
    exp_val = '{16'h0123, 16'h0456};
    s0 = start_cnt;
    d0 = done_cnt;
    start_scan(4'b0101, 3'd0, 1'b1, 1'b0);
    check("t1_busy", busy_out, 1);
    check("t1_mux0", mux_sel_out, 0);
    k = 0;
    while (!core_start_out && k < 100) begin @(negedge clk); k++; end
    check("t1_settle_lat", k, 8);
    wait_idle("t1_idle", 500);
    check("t1_starts", start_cnt - s0, 2);
    check("t1_dones", done_cnt - d0, 1);
    check("t1_done_ch", done_ch, 2);
    check("t1_left", exp_ch.size(), 0);
    // 4x oversampling, averaged then summed
    for (int a = 1; a >= 0; a--) begin
      core_vals = '{12'd100, 12'd101, 12'd102, 12'd103};
      exp_ch = '{1};
      exp_val = '{a != 0 ? 101 : 406};
      s0 = start_cnt;
      f0 = follow_cnt;
      start_scan(4'b0010, 3'd2, a[0], 1'b0);
      wait_idle("t2_idle", 500);
      check("t2_follow", follow_cnt - f0, 3);
      check("t2_starts", start_cnt - s0, 4);
      check("t2_left", exp_ch.size(), 0);
    end
    // oversampling exponent above the maximum clamps to 16 samples
    for (int a = 1; a >= 0; a--) begin
      core_vals.delete();
      repeat (16) core_vals.push_back(12'hFFF);
      exp_ch = '{0};
      exp_val = '{a != 0 ? 16'h0FFF : 16'hFFF0};
      s0 = start_cnt;
      start_scan(4'b0001, 3'd7, a[0], 1'b0);
      wait_idle("t3_idle", 1000);
      check("t3_starts", start_cnt - s0, 16);
      check("t3_left", exp_ch.size(), 0);
    end
    // core silent on ch1
    core_vals = '{12'h0AB};
    exp_ch = '{0};
    exp_val = '{16'h00AB};
    mute_ch = 1;
    d0 = done_cnt;
    tmo_gap = -1;
    start_scan(4'b0011, 3'd0, 1'b1, 1'b0);
    wait_idle("t4_idle", 500);
    check("t4_tmo_gap", tmo_gap, 64);
    check("t4_tmo_flag", timeout_out, 1);
    check("t4_dones", done_cnt - d0, 1);
    check("t4_done_no_result", done_ch, -2);
    check("t4_left", exp_ch.size(), 0);
    mute_ch = -1;
    // continuous: mask change mid-scan applies to the next scan only
    core_vals = '{12'h011, 12'h033};
    exp_ch = '{0, 3};
    exp_val = '{16'h0011, 16'h0033};
    d0 = done_cnt;
    start_scan(4'b0001, 3'd0, 1'b1, 1'b1);
    check("t5_tmo_clr", timeout_out, 0);
    ch_mask_in = 4'b1000;
    k = 0;
    do begin @(negedge clk); k++; end while (!scan_done_out && k < 300);
    check("t5_first_done", scan_done_out, 1);
    @(negedge clk);
    continuous_in = 1'b0;
    check("t5_restart_busy", busy_out, 1);
    check("t5_restart_mux", mux_sel_out, 3);
    wait_idle("t5_idle", 500);
    check("t5_dones", done_cnt - d0, 2);
    check("t5_left", exp_ch.size(), 0);
    // abort mid-conversion
    core_vals.delete();
    repeat (16) core_vals.push_back(12'h005);
    d0 = done_cnt;
    start_scan(4'b0001, 3'd4, 1'b1, 1'b0);
    wait_core_start("t6_conv_reached");
    repeat (3) @(negedge clk);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    check("abort_busy", busy_out, 0);
    check("abort_valid", result_valid_out, 0);
    check("abort_scan_done", scan_done_out, 0);
    repeat (40) @(negedge clk);
    check("abort_stays_idle", busy_out, 0);
    check("abort_no_done", done_cnt - d0, 0);
    core_vals.delete();
    // empty mask start is ignored
    s0 = start_cnt;
    start_scan(4'b0000, 3'd0, 1'b1, 1'b0);
    check("m0_busy", busy_out, 0);
    repeat (20) @(negedge clk);
    check("m0_starts", start_cnt - s0, 0);
    // reset mid-conversion
    repeat (16) core_vals.push_back(12'h007);
    start_scan(4'b0100, 3'd4, 1'b1, 1'b0);
    wait_core_start("t7_conv_reached");
    check("t7_mux", mux_sel_out, 2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_busy", busy_out, 0);
    check("rst2_mux", mux_sel_out, 0);
    check("rst2_core_start", core_start_out, 0);
    check("rst2_valid", result_valid_out, 0);
    check("rst2_result", result_out, 0);
    check("rst2_scan_done", scan_done_out, 0);
    rst = 1'b0;
    core_vals.delete();
    repeat (5) @(negedge clk);
    check("final_left", exp_ch.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
